// File: rtl/tdcpu_pkg.sv
// Shared definitions for the tdcpu_core_param CPU: opcodes, operand/destination selects and
// the instruction decoder. The decoder maps 1100/1000 to CALL/RET when the stack is built in.
package tdcpu_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B0 = 4'b1000;
  localparam logic [3:0] OP_OUT_B1 = 4'b1001;
  localparam logic [3:0] OP_OUT_I0 = 4'b1010;
  localparam logic [3:0] OP_OUT_I1 = 4'b1011;
  localparam logic [3:0] OP_JNC0   = 4'b1100;
  localparam logic [3:0] OP_JMP0   = 4'b1101;
  localparam logic [3:0] OP_JNC1   = 4'b1110;
  localparam logic [3:0] OP_JMP1   = 4'b1111;

  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_e;
  typedef enum logic [1:0] {DST_A, DST_B, DST_OUT, DST_NONE} dst_e;

  typedef struct packed {
    src_e src;
    dst_e dst;
    logic is_jmp;
    logic is_jnc;
    logic is_call;
    logic is_ret;
  } dec_t;

  function automatic int imm_width(input int data_w, input int pc_w);
    return (data_w > pc_w) ? data_w : pc_w;
  endfunction

  function automatic dec_t decode(input logic [3:0] op, input logic call_en);
    dec_t d;
    d = '{src: SRC_ZERO, dst: DST_NONE, is_jmp: 1'b0, is_jnc: 1'b0,
          is_call: 1'b0, is_ret: 1'b0};
    case (op)
      OP_ADD_A:  begin d.src = SRC_A;    d.dst = DST_A; end
      OP_MOV_AB: begin d.src = SRC_B;    d.dst = DST_A; end
      OP_IN_A:   begin d.src = SRC_IN;   d.dst = DST_A; end
      OP_MOV_AI: begin d.src = SRC_ZERO; d.dst = DST_A; end
      OP_MOV_BA: begin d.src = SRC_A;    d.dst = DST_B; end
      OP_ADD_B:  begin d.src = SRC_B;    d.dst = DST_B; end
      OP_IN_B:   begin d.src = SRC_IN;   d.dst = DST_B; end
      OP_MOV_BI: begin d.src = SRC_ZERO; d.dst = DST_B; end
      OP_OUT_B0, OP_OUT_B1: begin
        if (call_en && op == OP_OUT_B0) begin
          d.is_ret = 1'b1;
        end else begin
          d.src = SRC_B;
          d.dst = DST_OUT;
        end
      end
      OP_OUT_I0, OP_OUT_I1: d.dst = DST_OUT;
      OP_JNC0, OP_JNC1: begin
        if (call_en && op == OP_JNC0) d.is_call = 1'b1;
        else                          d.is_jnc  = 1'b1;
      end
      default: d.is_jmp = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tdcpu_if.sv
// Fetch/IO bundle between the CPU core (slave side) and the pad wrapper / ROM (master side).
// Instruction word is {op[3:0], im[IMM_W-1:0]} with IMM_W = max(DATA_W, PC_W).
interface tdcpu_if #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
);
  import tdcpu_pkg::*;

  localparam int IMM_W = imm_width(DATA_W, PC_W);

  logic                instr_valid;
  logic [IMM_W+3:0]    instr;
  logic [DATA_W-1:0]   in_port;
  logic [PC_W-1:0]     pc;
  logic [DATA_W-1:0]   out_port;
  logic                out_stb;
  logic                carry;
  logic                stk_err;

  modport master (
    output instr_valid, instr, in_port,
    input  pc, out_port, out_stb, carry, stk_err
  );

  modport slave (
    input  instr_valid, instr, in_port,
    output pc, out_port, out_stb, carry, stk_err
  );

endinterface

// File: rtl/tdcpu_ret_stack.sv
// LIFO of return addresses for CALL/RET. Only the fill count is reset; entries keep stale data.
// The caller guarantees push and pop are never asserted together.
module tdcpu_ret_stack #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW:0]     cnt;
  logic [AW-1:0]   top_idx;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = AW'(cnt - (AW+1)'(1));
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + (AW+1)'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[cnt[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tdcpu_core_param.sv
// Parametrised two-register accumulator CPU: A/B, in/out ports, carry, external instruction fetch
// with stall. Define TDCPU_CALL_EN to turn 1100/1000 into CALL/RET backed by a return stack.
module tdcpu_core_param
  import tdcpu_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int PC_W        = 4,
  parameter int STACK_DEPTH = 4
) (
  input logic    clk,
  input logic    reset,
  tdcpu_if.slave bus
);
  localparam int IMM_W = imm_width(DATA_W, PC_W);
`ifdef TDCPU_CALL_EN
  localparam logic CALL_EN = 1'b1;
`else
  localparam logic CALL_EN = 1'b0;
`endif

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_depth_check
    $error("tdcpu_core_param: STACK_DEPTH must be a power of 2 and at least 2");
  end

  logic [3:0]        op;
  logic [IMM_W-1:0]  im;
  dec_t              dec;
  logic [DATA_W-1:0] a, b, out_reg, src_val, res;
  logic [DATA_W:0]   sum;
  logic [PC_W-1:0]   pc, pc_inc, pc_next, im_pc;
  logic              carry, out_stb, alu_en, take_jump;

  assign op     = bus.instr[IMM_W+3:IMM_W];
  assign im     = bus.instr[IMM_W-1:0];
  assign dec    = decode(op, CALL_EN);
  assign im_pc  = im[PC_W-1:0];
  assign pc_inc = pc + PC_W'(1);

  always_comb begin
    src_val = '0;
    case (dec.src)
      SRC_A:   src_val = a;
      SRC_B:   src_val = b;
      SRC_IN:  src_val = bus.in_port;
      default: src_val = '0;
    endcase
  end

  // Jumps add im to zero, so their carry-out is always 0 and they clear the flag.
  assign sum       = {1'b0, src_val} + {1'b0, im[DATA_W-1:0]};
  assign res       = sum[DATA_W-1:0];
  assign take_jump = dec.is_jmp | dec.is_call | (dec.is_jnc & ~carry);
  assign alu_en    = bus.instr_valid & ~dec.is_call & ~dec.is_ret;

`ifdef TDCPU_CALL_EN
  logic            stk_full, stk_empty, stk_push, stk_pop, stk_err;
  logic [PC_W-1:0] stk_top;

  assign stk_push = bus.instr_valid & dec.is_call & ~stk_full;
  assign stk_pop  = bus.instr_valid & dec.is_ret & ~stk_empty;

  tdcpu_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .PC_W  (PC_W)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // A RET on an empty stack falls through to pc+1.
  always_comb begin
    pc_next = take_jump ? im_pc : pc_inc;
    if (dec.is_ret && !stk_empty) pc_next = stk_top;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stk_err <= 1'b0;
    end else if (bus.instr_valid &&
                 ((dec.is_call && stk_full) || (dec.is_ret && stk_empty))) begin
      stk_err <= 1'b1;
    end
  end

  assign bus.stk_err = stk_err;
`else
  assign pc_next     = take_jump ? im_pc : pc_inc;
  assign bus.stk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      a       <= '0;
      b       <= '0;
      out_reg <= '0;
      carry   <= 1'b0;
      out_stb <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      if (bus.instr_valid) pc <= pc_next;
      if (alu_en) begin
        carry <= sum[DATA_W];
        case (dec.dst)
          DST_A:   a <= res;
          DST_B:   b <= res;
          DST_OUT: begin
            out_reg <= res;
            out_stb <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pc       = pc;
  assign bus.out_port = out_reg;
  assign bus.out_stb  = out_stb;
  assign bus.carry    = carry;

endmodule

// File: tb/tb_tdcpu_core_param.sv
// Bench for tdcpu_core_param: a 4/4 and an 8/6 instance run the same stream against a
// table-level reference model; directed scenarios plus randomized instructions, stalls and resets.
module tb_tdcpu_core_param;

`ifdef TDCPU_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tdcpu_if #(.DATA_W(4), .PC_W(4)) bus0 ();
  tdcpu_if #(.DATA_W(8), .PC_W(6)) bus1 ();

  tdcpu_core_param #(.DATA_W(4), .PC_W(4), .STACK_DEPTH(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  tdcpu_core_param #(.DATA_W(8), .PC_W(6), .STACK_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit cur_rst, cur_valid;
  int cur_op, cur_im, cur_in;

  int dw[2]    = '{4, 8};
  int pw[2]    = '{4, 6};
  int depth[2] = '{2, 4};
  int m_pc[2], m_a[2], m_b[2], m_out[2], m_c[2], m_stb[2], m_err[2], m_sp[2];
  int m_stk[2][8];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: one instruction per valid cycle, straight from the opcode table.
  task automatic model_step(input int k);
    int dm, pm, nxt, tgt, opnd, s, sum;
    dm = (1 << dw[k]) - 1;
    pm = (1 << pw[k]) - 1;
    if (cur_rst) begin
      m_pc[k] = 0; m_a[k] = 0; m_b[k] = 0; m_out[k] = 0;
      m_c[k] = 0; m_stb[k] = 0; m_err[k] = 0; m_sp[k] = 0;
      return;
    end
    m_stb[k] = 0;
    if (!cur_valid) return;
    nxt  = (m_pc[k] + 1) & pm;
    tgt  = cur_im & pm;
    opnd = cur_im & dm;
    if (CALL_EN && cur_op == 12) begin
      if (m_sp[k] < depth[k]) begin
        m_stk[k][m_sp[k]] = nxt;
        m_sp[k]++;
      end else m_err[k] = 1;
      m_pc[k] = tgt;
      return;
    end
    if (CALL_EN && cur_op == 8) begin
      if (m_sp[k] > 0) begin
        m_sp[k]--;
        m_pc[k] = m_stk[k][m_sp[k]];
      end else begin
        m_pc[k]  = nxt;
        m_err[k] = 1;
      end
      return;
    end
    case (cur_op)
      0, 4:       s = m_a[k];
      1, 5, 8, 9: s = m_b[k];
      2, 6:       s = cur_in & dm;
      default:    s = 0;
    endcase
    sum = s + opnd;
    if (cur_op < 4)       m_a[k] = sum & dm;
    else if (cur_op < 8)  m_b[k] = sum & dm;
    else if (cur_op < 12) begin
      m_out[k] = sum & dm;
      m_stb[k] = 1;
    end
    if (cur_op == 13 || cur_op == 15)                       m_pc[k] = tgt;
    else if ((cur_op == 12 || cur_op == 14) && m_c[k] == 0) m_pc[k] = tgt;
    else                                                    m_pc[k] = nxt;
    m_c[k] = sum >> dw[k];
  endtask

  task automatic compare_all();
    check("pc0",      bus0.pc,       m_pc[0]);
    check("out0",     bus0.out_port, m_out[0]);
    check("stb0",     bus0.out_stb,  m_stb[0]);
    check("carry0",   bus0.carry,    m_c[0]);
    check("stk_err0", bus0.stk_err,  m_err[0]);
    check("pc1",      bus1.pc,       m_pc[1]);
    check("out1",     bus1.out_port, m_out[1]);
    check("stb1",     bus1.out_stb,  m_stb[1]);
    check("carry1",   bus1.carry,    m_c[1]);
    check("stk_err1", bus1.stk_err,  m_err[1]);
  endtask

  task automatic apply();
    reset            = cur_rst;
    bus0.instr_valid = cur_valid;
    bus1.instr_valid = cur_valid;
    bus0.instr       = {cur_op[3:0], cur_im[3:0]};
    bus1.instr       = {cur_op[3:0], cur_im[7:0]};
    bus0.in_port     = cur_in[3:0];
    bus1.in_port     = cur_in[7:0];
  endtask

  task automatic cycle();
    apply();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic exec(input int op, input int im);
    cur_rst   = 1'b0;
    cur_valid = 1'b1;
    cur_op    = op;
    cur_im    = im;
    cycle();
  endtask

  initial begin
    cur_rst = 1'b1; cur_valid = 1'b1; cur_op = 13; cur_im = 5; cur_in = 0;
    cycle();
    cycle();
    check("rst_pc",    bus0.pc,       0);
    check("rst_out",   bus0.out_port, 0);
    check("rst_carry", bus0.carry,    0);
    check("rst_stb",   bus0.out_stb,  0);

    // Carry loop and JNC
    exec(3, 14);
    exec(0, 1);
    exec(0, 1);
    check("loop_carry", bus0.carry, 1);
    exec(14, 3);
    check("jnc_not_taken_pc", bus0.pc, 4);
    check("jnc_clears_carry", bus0.carry, 0);
    exec(14, 3);
    check("jnc_taken_pc", bus0.pc, 3);
    exec(4, 0);
    exec(9, 0);
    check("a_wrapped_to_0", bus0.out_port, 0);

    // IN / OUT and strobe
    cur_in = 5;
    exec(6, 0);
    exec(9, 2);
    check("out_b_plus_2", bus0.out_port, 7);
    check("out_stb_pulse", bus0.out_stb, 1);
    exec(0, 0);
    check("out_stb_one_clk", bus0.out_stb, 0);
    exec(10, 9);
    exec(10, 9);
    check("out_im9", bus0.out_port, 9);
    check("out_stb_b2b", bus0.out_stb, 1);

    // Stall with toggling inputs
    cur_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur_op = $urandom_range(0, 15);
      cur_im = $urandom_range(0, 255);
      cur_in = cur_in ^ 255;
      cycle();
    end
    check("stall_pc",  bus0.pc,       10);
    check("stall_out", bus0.out_port, 9);
    check("stall_stb", bus0.out_stb,  0);
    exec(0, 0);
    check("resume_pc", bus0.pc, 11);

    // PC wrap on the 4/4 instance
    exec(13, 0);
    for (int i = 0; i < 15; i++) exec(0, 0);
    check("pc_at_15", bus0.pc, 15);
    exec(0, 0);
    check("pc_wrap_0", bus0.pc, 0);

    // Wide instance: 8-bit carry and 6-bit jump target
    exec(3, 1);
    exec(0, 255);
    check("w_carry", bus1.carry, 1);
    exec(4, 0);
    exec(9, 0);
    check("w_a_zero", bus1.out_port, 0);
    exec(13, 63);
    check("w_jmp63", bus1.pc, 63);
    exec(0, 0);
    check("w_pc_wrap", bus1.pc, 0);

`ifdef TDCPU_CALL_EN
    cur_rst = 1'b1;
    cycle();
    exec(12, 8);
    exec(12, 12);
    exec(8, 0);
    check("ret_inner", bus0.pc, 9);
    exec(8, 0);
    check("ret_outer", bus0.pc, 1);
    check("no_err", bus0.stk_err, 0);
    exec(12, 8);
    exec(12, 12);
    exec(12, 4);
    check("ovf_jumps", bus0.pc, 4);
    check("ovf_err", bus0.stk_err, 1);
    exec(8, 0);
    exec(8, 0);
    check("ret_after_ovf", bus0.pc, 2);
    exec(8, 0);
    check("udf_pc_inc", bus0.pc, 3);
    exec(0, 0);
    exec(0, 0);
    check("err_sticky", bus0.stk_err, 1);
    cur_rst = 1'b1;
    cycle();
    check("err_cleared", bus0.stk_err, 0);
`endif

    // Randomized stream
    for (int i = 0; i < 3000; i++) begin
      cur_rst   = ($urandom_range(0, 99) == 0);
      cur_valid = ($urandom_range(0, 4) != 0);
      cur_op    = $urandom_range(0, 15);
      cur_im    = $urandom_range(0, 255);
      cur_in    = $urandom_range(0, 255);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
